uart_tx: RTL and testbench
==========================

# uart_tx

Byte-wide UART transmitter. It serializes 8-bit words onto the tx pin as 8N1 frames by default, with optional parity and a second stop bit. Bit timing comes from the same 16x-oversampled baud tick that feeds the receiver, so one baud generator serves both directions. It sits between the host-side logic and the tx pin and uses a start/busy/done handshake.

## Interface

- PARITY, default 0: 0 = none, 1 = odd, 2 = even; other values behave as 0.
- STOP_BITS, default 1: 1 or 2 stop bits; other values behave as 1.

- clk  input  1  domain clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- tx_clk  input  1  baud tick at 16x baud rate; one clk cycle wide; acts as an enable, not a clock.
- enabled  input  1  transmitter enable; gates acceptance of new frames only.
- data  input  8  byte to send; sampled only in the cycle start is accepted.
- start  input  1  transmit request; level-sampled each clk cycle.
- tx  output  1  serial line, registered; idle high.
- busy  output  1  frame in progress, registered.
- done  output  1  one-clk pulse at the end of a frame, registered.

## Operation

- States:
  - IDLE: tx=1, busy=0.
  - START: tx=0.
  - DATA: tx=shift[0], LSB first.
  - PARITY: only when PARITY is 1 or 2.
  - STOP: tx=1, for STOP_BITS bit-times.
- Reset: in the cycle after rst=1, tx=1, busy=0, done=0, state=IDLE, tick counter=0, bit index=0, shift register=0. Reset wins over every other input, including in the middle of a frame. The line returns high immediately and no done pulse is produced.
- Accept: a request is accepted in any clk cycle (no tx_clk needed) where state=IDLE, enabled=1 and start=1.
  - On accept: data is latched into the shift register and parity is computed from the latched data.
  - Next state is START; the tick counter clears.
- Bit-time: every non-IDLE bit lasts exactly 16 tx_clk ticks.
  - The 4-bit tick counter increments on each tx_clk while state≠IDLE.
  - On the tick where counter=15, the counter wraps to 0 and the FSM advances to the next bit.
- DATA: bit index 0..7; the shift register shifts right on each bit advance. After bit 7, go to PARITY if enabled, else STOP.
- Parity bit value:
  - Even parity: XOR of data.
  - Odd parity: ~XOR of data.
- STOP: with STOP_BITS=2 it lasts 32 ticks, using a stop counter. On the final tick the FSM goes to IDLE and done pulses.
- start while busy is ignored; no queueing.
- Deasserting enabled in the middle of a frame does not abort it; the frame completes normally.
- data changing after accept has no effect on the frame in progress.

## Timing

- Accept in cycle N: at N+1, busy=1 and tx=0. Ticks counted for the start bit are those at cycles ≥ N+1.
- Each bit change on tx happens in the clk cycle after the tx_clk that ends the previous bit.
- Frame length is (1 + 8 + P + STOP_BITS) × 16 ticks, where P=1 if parity is on.
  - 8N1: 160 ticks.
  - 8E2: 192 ticks.
- End of frame: in the cycle after the last stop tick, done=1, busy=0, tx=1 and state=IDLE. done is low in every other cycle.
- Back-to-back: start=1 in the done cycle is accepted, since busy=0 and state=IDLE. tx falls at the following cycle, giving zero idle bit-times between frames.
- tx_clk asserted in the same cycle as an accept does not count toward the start bit.
- tx_clk arriving continuously (every cycle) is legal; a bit then lasts 16 clk cycles.

## Test plan

- Reset: hold rst=1 for 3 cycles with start=1, enabled=1 and tx_clk toggling → tx=1, busy=0, done=0 throughout and one cycle after release. No frame starts until start is sampled after reset.
- 8N1 frame, 0xA5, tx_clk every 4 clk:
  - tx = 0,1,0,1,0,0,1,0,1,1, with each level held exactly 64 clk.
  - busy is high for 640 clk.
  - done is a single pulse 641 cycles after accept.
- PARITY=2, STOP_BITS=2:
  - Send 0x55 → parity bit 0; the stop level lasts 128 clk.
  - With PARITY=1, 0x55 → parity bit 1.
  - Send 0x07 with PARITY=2 → parity bit 1.
- Back-to-back: hold start=1 continuously with data 0x01 then 0x80 → done and the next tx fall occur on consecutive cycles. The second frame decodes as 0x80. A receiver using the same tx_clk, looped back, reports both bytes with err=0.
- Ignored requests: pulse start with data=0xFF in the middle of a frame, and drop enabled in the middle of a frame → the current frame completes unchanged and no extra frame follows.
- Reset during the DATA state: assert rst at bit 3 → tx=1 and busy=0 the next cycle, with no done pulse. A new start then sends a full correct frame.

Source files
------------

// File: rtl/uart_tx_if.sv
// Host-side handshake bundle for the UART transmitter: baud tick, request,
// byte, and the registered line/status outputs.
interface uart_tx_if;
  logic       tx_clk;
  logic       enabled;
  logic [7:0] data;
  logic       start;
  logic       tx;
  logic       busy;
  logic       done;

  // Host side: drives tick, enable and requests; observes line and status.
  modport master (
    output tx_clk, enabled, data, start,
    input  tx, busy, done
  );

  // Transmitter side.
  modport slave (
    input  tx_clk, enabled, data, start,
    output tx, busy, done
  );
endinterface

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter. Frames are start + 8 data bits (LSB first)
// + optional parity + 1 or 2 stop bits. Each bit lasts 16 ticks of the
// shared 16x baud enable, so the receiver's baud generator can be reused.
module uart_tx #(
  parameter int PARITY    = 0,  // 0 none, 1 odd, 2 even; anything else = none
  parameter int STOP_BITS = 1   // 1 or 2; anything else = 1
) (
  input logic      clk,
  input logic      rst,
  uart_tx_if.slave bus
);

  localparam bit PAR_EN   = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD  = (PARITY == 1);
  localparam bit TWO_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t     state_reg;
  logic [3:0] tick_reg;
  logic [2:0] bit_idx_reg;
  logic [7:0] shift_reg;
  logic       parity_reg;
  logic       stop_cnt_reg;
  logic       tx_reg;
  logic       busy_reg;
  logic       done_reg;

  // Frame FSM with registered line and status outputs. The bit advances on
  // the 16th tick of the current bit; the new level shows one clk later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      tick_reg     <= 4'd0;
      bit_idx_reg  <= 3'd0;
      shift_reg    <= 8'd0;
      parity_reg   <= 1'b0;
      stop_cnt_reg <= 1'b0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          tx_reg   <= 1'b1;
          busy_reg <= 1'b0;
          // A tick coinciding with accept is deliberately not counted.
          if (bus.enabled && bus.start) begin
            shift_reg    <= bus.data;
            parity_reg   <= PAR_ODD ? ~(^bus.data) : (^bus.data);
            tick_reg     <= 4'd0;
            bit_idx_reg  <= 3'd0;
            stop_cnt_reg <= 1'b0;
            tx_reg       <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= S_START;
          end
        end
        default: begin
          if (bus.tx_clk) begin
            tick_reg <= tick_reg + 4'd1;
            if (tick_reg == 4'd15) begin
              case (state_reg)
                S_START: begin
                  tx_reg      <= shift_reg[0];
                  bit_idx_reg <= 3'd0;
                  state_reg   <= S_DATA;
                end
                S_DATA: begin
                  shift_reg <= {1'b0, shift_reg[7:1]};
                  if (bit_idx_reg == 3'd7) begin
                    if (PAR_EN) begin
                      tx_reg    <= parity_reg;
                      state_reg <= S_PARITY;
                    end else begin
                      tx_reg    <= 1'b1;
                      state_reg <= S_STOP;
                    end
                  end else begin
                    tx_reg      <= shift_reg[1];
                    bit_idx_reg <= bit_idx_reg + 3'd1;
                  end
                end
                S_PARITY: begin
                  tx_reg    <= 1'b1;
                  state_reg <= S_STOP;
                end
                S_STOP: begin
                  // Second stop bit reuses the tick counter for another 16 ticks.
                  if (TWO_STOP && !stop_cnt_reg) begin
                    stop_cnt_reg <= 1'b1;
                  end else begin
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= S_IDLE;
                  end
                end
                default: state_reg <= S_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign bus.tx   = tx_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (8N1, 8E2, 8O2) share the
// same stimulus; one instance at a time is selected for checking.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_clk_s = 1'b0;
  logic       enabled = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;

  int checks = 0;
  int errors = 0;
  int ph = 0;
  int tick_mode = 0;  // 0 none, 1 every 4 clk, 2 every clk
  int sel = 0;

  logic tx_sel, busy_sel, done_sel;

  uart_tx_if u0();
  uart_tx_if u1();
  uart_tx_if u2();

  assign u0.tx_clk = tx_clk_s;
  assign u0.enabled = enabled;
  assign u0.start = start;
  assign u0.data = data;
  assign u1.tx_clk = tx_clk_s;
  assign u1.enabled = enabled;
  assign u1.start = start;
  assign u1.data = data;
  assign u2.tx_clk = tx_clk_s;
  assign u2.enabled = enabled;
  assign u2.start = start;
  assign u2.data = data;

  uart_tx #(.PARITY(0), .STOP_BITS(1)) dut0 (.clk(clk), .rst(rst), .bus(u0));
  uart_tx #(.PARITY(2), .STOP_BITS(2)) dut1 (.clk(clk), .rst(rst), .bus(u1));
  uart_tx #(.PARITY(1), .STOP_BITS(2)) dut2 (.clk(clk), .rst(rst), .bus(u2));

  always #5 clk = ~clk;

  // Select which instance's outputs are checked.
  always_comb begin
    tx_sel = u0.tx;
    busy_sel = u0.busy;
    done_sel = u0.done;
    case (sel)
      1: begin tx_sel = u1.tx; busy_sel = u1.busy; done_sel = u1.done; end
      2: begin tx_sel = u2.tx; busy_sel = u2.busy; done_sel = u2.done; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clk cycle; inputs are already set, outputs are read 1 time unit after the edge.
  task automatic step();
    tx_clk_s = (tick_mode == 2) || (tick_mode == 1 && (ph % 4) == 0);
    @(posedge clk);
    #1;
    ph++;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((u0.busy || u1.busy || u2.busy) && n < 3000) begin
      step();
      n++;
    end
    check("idle_timeout", {31'd0, n < 3000}, 32'd1);
    step();
  endtask

  // Send one byte and check every cycle of the selected instance's frame.
  task automatic run_frame(input int s, input int mode, input logic [7:0] b, input int nbits,
                           input logic [11:0] exp_bits, input int blen, input bit disturb,
                           input string tag);
    int bad_tx = 0;
    int bad_busy = 0;
    int bad_done = 0;
    logic [11:0] mid = 12'd0;
    sel = s;
    tick_mode = mode;
    start = 1'b0;
    enabled = 1'b1;
    if (mode == 1) while ((ph % 4) != 0) step();
    data = b;
    start = 1'b1;
    step();
    start = 1'b0;
    data = ~b;
    for (int k = 0; k < nbits * blen; k++) begin
      if (tx_sel !== exp_bits[k / blen]) bad_tx++;
      if (busy_sel !== 1'b1) bad_busy++;
      if (done_sel !== 1'b0) bad_done++;
      if ((k % blen) == blen / 2) mid[k / blen] = tx_sel;
      if (disturb) begin
        if (k == 200) begin start = 1'b1; data = 8'hFF; end
        else if (k == 201) start = 1'b0;
        if (k == 300) enabled = 1'b0;
      end
      step();
    end
    check({tag, " bits"}, {20'd0, mid}, {20'd0, exp_bits});
    check({tag, " tx_cycles_wrong"}, bad_tx, 0);
    check({tag, " busy_cycles_low"}, bad_busy, 0);
    check({tag, " done_early"}, bad_done, 0);
    check({tag, " end tx/busy/done"}, {29'd0, tx_sel, busy_sel, done_sel}, 32'b101);
    enabled = 1'b1;
    step();
    check({tag, " done_one_cycle"}, {31'd0, done_sel}, 32'd0);
    $display("frame %s dut=%0d byte=%h bits=%03h", tag, s, b, mid);
    wait_idle();
  endtask

  initial begin
    int n_done;
    int n_busy;
    logic [7:0] rx;

    // Reset held with requests and continuous ticks present.
    rst = 1'b1; start = 1'b1; enabled = 1'b1; tick_mode = 2;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_hold", {29'd0, u0.tx & u1.tx & u2.tx, u0.busy | u1.busy | u2.busy,
                           u0.done | u1.done | u2.done}, 32'b100);
    end
    rst = 1'b0; start = 1'b0;
    step();
    check("after_reset", {29'd0, u0.tx, u0.busy, u0.done}, 32'b100);
    n_busy = 0;
    for (int i = 0; i < 40; i++) begin step(); if (u0.busy) n_busy++; end
    check("no_frame_after_reset", n_busy, 0);
    $display("reset sequence done");

    // 8N1 0xA5, tick every 4 clk: ten levels of 64 clk, done after 640.
    run_frame(0, 1, 8'hA5, 10, {2'b00, 1'b1, 8'hA5, 1'b0}, 64, 1'b0, "8N1_A5");
    // Continuous tick: 16 clk per bit.
    run_frame(0, 2, 8'h3C, 10, {2'b00, 1'b1, 8'h3C, 1'b0}, 16, 1'b0, "8N1_3C_fast");
    // Even parity 0x55 -> 0, two stop bits (128 clk of stop level).
    run_frame(1, 1, 8'h55, 12, {2'b11, 1'b0, 8'h55, 1'b0}, 64, 1'b0, "8E2_55");
    // Odd parity 0x55 -> 1.
    run_frame(2, 1, 8'h55, 12, {2'b11, 1'b1, 8'h55, 1'b0}, 64, 1'b0, "8O2_55");
    // Even parity 0x07 -> 1.
    run_frame(1, 1, 8'h07, 12, {2'b11, 1'b1, 8'h07, 1'b0}, 64, 1'b0, "8E2_07");
    // Mid-frame start with 0xFF and enable drop must not disturb the frame.
    run_frame(0, 1, 8'hA5, 10, {2'b00, 1'b1, 8'hA5, 1'b0}, 64, 1'b1, "8N1_A5_disturbed");
    n_busy = 0;
    for (int i = 0; i < 100; i++) begin step(); if (u0.busy) n_busy++; end
    check("no_extra_frame", n_busy, 0);

    // Back-to-back with start held: 0x01 then 0x80.
    sel = 0; tick_mode = 1; enabled = 1'b1;
    while ((ph % 4) != 0) step();
    data = 8'h01; start = 1'b1;
    step();
    data = 8'h80;
    for (int n = 1; n <= 640; n++) step();
    check("b2b done", {29'd0, u0.tx, u0.busy, u0.done}, 32'b101);
    step();
    check("b2b next_fall", {30'd0, u0.tx, u0.busy}, 32'b01);
    start = 1'b0;
    rx = 8'h00;
    for (int n = 642; n <= 1280; n++) begin
      step();
      for (int i = 0; i < 8; i++) if (n == 736 + 64 * i) rx[i] = u0.tx;
      if (n == 1279) check("b2b second_not_done_early", {31'd0, u0.done}, 32'd0);
    end
    check("b2b second_byte", {24'd0, rx}, 32'h80);
    check("b2b second_done", {29'd0, u0.tx, u0.busy, u0.done}, 32'b101);
    $display("back-to-back 0x01,0x80 second=%h", rx);
    wait_idle();

    // Reset during data bit 3.
    sel = 0; tick_mode = 1;
    while ((ph % 4) != 0) step();
    data = 8'hA5; start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 270; n++) step();
    check("pre_reset_busy", {31'd0, u0.busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_reset", {29'd0, u0.tx, u0.busy, u0.done}, 32'b100);
    n_done = 0; n_busy = 0;
    for (int i = 0; i < 800; i++) begin
      step();
      if (u0.done) n_done++;
      if (u0.busy) n_busy++;
    end
    check("mid_reset_no_done", n_done, 0);
    check("mid_reset_stays_idle", n_busy, 0);
    $display("reset during data bit 3 done");
    run_frame(0, 1, 8'hA5, 10, {2'b00, 1'b1, 8'hA5, 1'b0}, 64, 1'b0, "8N1_A5_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
